// File: rtl/rosetta_pkg.sv
// rosetta_pkg: shared definitions for the ARTEMIS core dispatcher.
//   core_state_e : per-core FSM state encoding (2 bits).
//   lowest_set() : index of the lowest set bit of a 16-bit mask, used by
//                  both the dispatch selector and the event selector.
package rosetta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESET  = 2'd1,
        ST_WORK   = 2'd2,
        ST_REPORT = 2'd3
    } core_state_e;

    localparam int MAX_CORES = 16;
    localparam int MAX_ID_W  = 4;

    // Returns 0 for an empty mask; callers qualify with their own "any" bit.
    function automatic logic [MAX_ID_W-1:0] lowest_set(input logic [MAX_CORES-1:0] v);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rosetta_core_slot.sv
// rosetta_core_slot: state machine for one managed core.
//   clk, rst      : clock, synchronous active-high reset
//   dispatch      : this slot is given a job this cycle (only acted on in IDLE)
//   core_done     : core completion, sampled only in WORK
//   evt_ack       : this slot's completion event was accepted
//   core_rst      : registered core reset, high for RST_CYCLES cycles after dispatch
//   busy          : state != IDLE
//   report        : state == REPORT (event waiting to be captured/accepted)
//   timeout_flag  : 1 when the REPORT was caused by the watchdog
module rosetta_core_slot
    import rosetta_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic dispatch,
    input  logic core_done,
    input  logic evt_ack,
    output logic core_rst,
    output logic busy,
    output logic report,
    output logic timeout_flag
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    core_state_e     state_q;
    logic [RC_W-1:0] rcnt_q;
    logic [WD_W-1:0] wdog_q;
    logic            tflag_q;
    logic            core_rst_q;

    // Counters are cleared on state entry and the state is left on the
    // terminal count, so neither counter can wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            wdog_q     <= '0;
            tflag_q    <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dispatch) begin
                        state_q    <= ST_RESET;
                        rcnt_q     <= '0;
                        core_rst_q <= 1'b1;
                        tflag_q    <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rcnt_q == RC_LAST) begin
                        state_q    <= ST_WORK;
                        wdog_q     <= '0;
                        core_rst_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                ST_WORK: begin
                    // done has priority over a same-cycle watchdog expiry
                    if (core_done) begin
                        state_q <= ST_REPORT;
                        tflag_q <= 1'b0;
                    end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                        state_q <= ST_REPORT;
                        tflag_q <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (evt_ack) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_rst     = core_rst_q;
    assign busy         = (state_q != ST_IDLE);
    assign report       = (state_q == ST_REPORT);
    assign timeout_flag = tflag_q;

endmodule

// File: rtl/rosetta_core_dispatcher.sv
// rosetta_core_dispatcher: dispatches jobs to NUM_CORES ARTEMIS cores and
// funnels their completions into a single back-pressured event channel.
//   clk, rst              : clock, synchronous active-high reset
//   start_valid/ready/id  : job request; start_id = lowest-index IDLE core
//   core_rst[NUM_CORES]   : registered per-core reset
//   core_busy[NUM_CORES]  : per-core state != IDLE
//   core_done[NUM_CORES]  : per-core completion (sampled only in WORK)
//   evt_valid/ready       : completion event handshake
//   evt_id, evt_timeout   : reporting core, 1 = watchdog expiry
module rosetta_core_dispatcher
    import rosetta_pkg::*;
#(
    parameter  int NUM_CORES  = 4,
    parameter  int RST_CYCLES = 2,
    parameter  int TIMEOUT    = 1024,
    localparam int ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    output logic [ID_W-1:0]      start_id,
    output logic [NUM_CORES-1:0] core_rst,
    output logic [NUM_CORES-1:0] core_busy,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [ID_W-1:0]      evt_id,
    output logic                 evt_timeout
);

    logic [NUM_CORES-1:0] busy, report, tflag, dispatch, evt_ack, held;
    logic [MAX_CORES-1:0] idle_ext, pend_ext, tflag_ext;
    logic [MAX_ID_W-1:0]  free_sel, pend_sel;
    logic                 unused_sel_bits;

    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic            evt_timeout_q, evt_timeout_d;
    logic            evt_hs;

    // Zero-extend per-core masks to the package selector width.
    always_comb begin
        idle_ext  = '0;
        pend_ext  = '0;
        tflag_ext = '0;
        idle_ext[NUM_CORES-1:0]  = ~busy;
        // the core already held in the event register is not pending again
        pend_ext[NUM_CORES-1:0]  = report & ~held;
        tflag_ext[NUM_CORES-1:0] = tflag;
    end

    assign free_sel        = lowest_set(idle_ext);
    assign pend_sel        = lowest_set(pend_ext);
    assign unused_sel_bits = ^{free_sel, pend_sel};

    // Dispatch selection depends on registered state only.
    assign start_ready = |idle_ext;
    assign start_id    = free_sel[ID_W-1:0];

    assign evt_hs = evt_valid_q && evt_ready;

    // Event register: cleared on handshake, and refilled on the same edge
    // when another core is waiting, so events can stream back-to-back.
    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_id_d      = evt_id_q;
        evt_timeout_d = evt_timeout_q;
        if (evt_hs) begin
            evt_valid_d   = 1'b0;
            evt_id_d      = '0;
            evt_timeout_d = 1'b0;
        end
        if ((!evt_valid_q || evt_hs) && |pend_ext) begin
            evt_valid_d   = 1'b1;
            evt_id_d      = pend_sel[ID_W-1:0];
            evt_timeout_d = tflag_ext[pend_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q   <= 1'b0;
            evt_id_q      <= '0;
            evt_timeout_q <= 1'b0;
        end else begin
            evt_valid_q   <= evt_valid_d;
            evt_id_q      <= evt_id_d;
            evt_timeout_q <= evt_timeout_d;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        assign held[i]     = evt_valid_q && (evt_id_q == ID_W'(i));
        assign evt_ack[i]  = held[i] && evt_ready;
        assign dispatch[i] = start_valid && !busy[i] && (free_sel == MAX_ID_W'(i));

        rosetta_core_slot #(
            .RST_CYCLES (RST_CYCLES),
            .TIMEOUT    (TIMEOUT)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .dispatch     (dispatch[i]),
            .core_done    (core_done[i]),
            .evt_ack      (evt_ack[i]),
            .core_rst     (core_rst[i]),
            .busy         (busy[i]),
            .report       (report[i]),
            .timeout_flag (tflag[i])
        );
    end

    assign core_busy   = busy;
    assign evt_valid   = evt_valid_q;
    assign evt_id      = evt_id_q;
    assign evt_timeout = evt_timeout_q;

endmodule

// File: doc/rosetta_core_dispatcher.md
# rosetta_core_dispatcher

Parametrised successor of the single-core start/done controller: dispatches jobs to `NUM_CORES` ARTEMIS cores, each with its own IDLE/RESET/WORK/REPORT state machine. Behaviour beyond the single-core controller:
- multi-cycle registered core reset;
- per-core watchdog timeout;
- back-pressured completion-event channel.

It sits between the host command interface and the core array.

## Interface
Parameters:
- `NUM_CORES`, 4 — number of managed cores; 1..16.
- `RST_CYCLES`, 2 — cycles `core_rst[i]` is held after dispatch; ≥1.
- `TIMEOUT`, 1024 — maximum WORK cycles before forced completion; 0 disables the watchdog.
- `ID_W`, derived — max(1, clog2(NUM_CORES)).

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset: synchronous, active-high; clock clk.
- `start_valid` in 1 — job request.
- `start_ready` out 1 — at least one core is IDLE.
- `start_id` out ID_W — core that takes the job; meaningful when `start_ready`.
- `core_rst` out NUM_CORES — per-core reset, registered.
- `core_busy` out NUM_CORES — core state ≠ IDLE.
- `core_done` in NUM_CORES — per-core completion, sampled only in WORK.
- `evt_valid` out 1 — completion event pending.
- `evt_ready` in 1 — event accepted.
- `evt_id` out ID_W — core reporting.
- `evt_timeout` out 1 — 1 = watchdog expiry, 0 = normal done.

## Operation
- **Dispatch.** A handshake is `start_valid && start_ready`. The chosen core is the lowest-index IDLE core, which `start_id` already shows combinationally. `start_ready`/`start_id` are combinational from registered state only, never from `start_valid`.
- **Per-core FSM:**
  - IDLE → RESET on dispatch.
  - RESET: `core_rst[i]` = 1; the counter runs RST_CYCLES cycles, then → WORK.
  - WORK: the watchdog counts cycles spent in WORK.
    - `core_done[i]` = 1 → REPORT with timeout flag 0.
    - Watchdog reaches TIMEOUT (TIMEOUT ≠ 0) → REPORT with timeout flag 1.
    - done and expiry in the same cycle → done wins, flag 0.
  - REPORT: waits for its event to be accepted, then → IDLE.
- **Event channel:**
  - When no event is held, the lowest-index core in REPORT is captured into the event registers, giving `evt_valid` = 1 on the next cycle.
  - `evt_id`/`evt_timeout` are stable while `evt_valid && !evt_ready`.
  - On handshake, the reporting core → IDLE and the event register clears. The next pending event may be captured on the same edge, so `evt_valid` can stay high on back-to-back cycles.
- **Ignored inputs.** `core_done` is ignored in IDLE, RESET and REPORT. `evt_ready` is ignored when `evt_valid` = 0.
- **Widths.** RESET counter width is clog2(RST_CYCLES+1). Watchdog width is clog2(TIMEOUT+1). Counters clear on state entry and never wrap.

## Timing
- **Reset values.** `rst` forces all cores to IDLE and clears all counters. `core_rst` = 0, `core_busy` = 0, `evt_valid` = 0, `evt_id` = 0, `evt_timeout` = 0. `start_ready` = 1 and `start_id` = 0 from the first cycle after reset.
- **Reset mid-operation.** Pending events and active jobs are discarded without a report.
- **Dispatch timing.** Handshake at cycle t:
  - `core_rst[i]` = 1 and `core_busy[i]` = 1 on cycles t+1 … t+RST_CYCLES;
  - WORK from t+RST_CYCLES+1.
- **Done timing.** `core_done` sampled at cycle d → REPORT at d+1 → `evt_valid` at d+2 (if the event register is free).
- **Watchdog timing.** WORK entered at w with no done → REPORT at w+TIMEOUT → event at w+TIMEOUT+1 with `evt_timeout` = 1.
- **Concurrent events.** A dispatch and an event handshake may occur in the same cycle. A core freed by an event handshake at t is dispatchable from t+1.

## Structure
- **Shared package `rosetta_pkg`:**
  - core state encoding (ST_IDLE, ST_RESET, ST_WORK, ST_REPORT, 2 bits);
  - the lowest-index-set-bit priority function, reused by the dispatch and event selectors.
- **Sub-module `rosetta_core_slot`:** one per core, generated NUM_CORES times. It holds the FSM, RESET counter, watchdog and timeout flag.
  - Inputs: `dispatch`, `core_done`, `evt_ack`.
  - Outputs: `core_rst`, `busy`, `report`, `timeout_flag`.
- **Top level:** dispatch selector, event capture register, and a generate loop over the slots.

## Test plan
- **Single job** (NUM_CORES=4, RST_CYCLES=2): start at cycle 0 → `start_id` = 0, `core_rst[0]` = 1 on cycles 1–2. `core_done[0]` at cycle 10 → `evt_valid` at 12 with `evt_id` = 0, `evt_timeout` = 0, `evt_ready` = 1. `core_busy[0]` = 0 from cycle 13.
- **Fill:** `start_valid` held for 5 cycles → ids 0, 1, 2, 3 dispatched on cycles 0–3. `start_ready` = 0 from cycle 4 until the first event handshake.
- **Simultaneous done:** cores 1 and 3 done in the same cycle d, `evt_ready` = 1 → event id 1 at d+2, id 3 at d+3.
- **Back-pressure:** `evt_ready` = 0 for 5 cycles with an event pending → `evt_valid`/`evt_id`/`evt_timeout` constant and the core stays busy. Other cores still dispatch and complete, and their events follow after acceptance.
- **Watchdog** (TIMEOUT=8): no done → `evt_timeout` = 1 at w+9. `core_done` at w+7 → `evt_timeout` = 0. With TIMEOUT=0, no event is produced after 10 000 cycles.
- **Reset mid-job:** `rst` pulsed while cores 0/2 are in WORK and one event is pending → next cycle all outputs are at reset values. No stale event appears afterwards, and `start_id` = 0.
